// File: rtl/tft_spi_seq_if.sv
// Avalon-MM slave bus bundle for the TFT SPI sequencer.
interface tft_spi_seq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tft_spi_seq.sv
// Avalon-MM TFT SPI sequencer: FIFO of DC-tagged bytes shifted out in SPI mode 0.
// Optional IRQEN register and level interrupt enabled by defining TFT_SEQ_IRQ_EN.
module tft_spi_seq #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  tft_spi_seq_if.slave    bus,
  output logic            tft_dc,
  output logic            tft_cs_n,
  output logic            tft_sclk,
  output logic            tft_mosi,
  output logic            irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [LW-1:0]    level;
  logic             empty, full, wr, push, push_ok, pop, busy, half_done;
  logic             ovf, ie, irq_pend;
  logic [8:0]       head;
  state_t           state;
  logic [7:0]       shreg;
  logic [2:0]       bitcnt;
  logic [DIV_W-1:0] hcnt, div_lat, div_reg;
  logic             unused_wd;

  assign empty     = (level == '0);
  assign full      = (level == LW'(FIFO_DEPTH));
  assign wr        = bus.chipselect & ~bus.write_n;
  assign push      = wr && (bus.address == 2'd0);
  assign push_ok   = push & ~full;
  assign head      = mem[rptr];
  assign half_done = (hcnt == div_lat);
  assign busy      = (state != IDLE) || !empty;
  assign tft_mosi  = shreg[7];
  assign unused_wd = &{1'b0, bus.writedata};

  // A byte load happens from IDLE, or at the end of the last HIGH phase when more data waits.
  assign pop = !empty && ((state == IDLE) ||
                          (state == HIGH && half_done && bitcnt == 3'd0));

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= bus.writedata[8:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf     <= 1'b0;
      div_reg <= DIV_W'(4);
      ie      <= 1'b0;
    end else begin
      if (push && full)
        ovf <= 1'b1;
      else if (wr && bus.address == 2'd1 && bus.writedata[3])
        ovf <= 1'b0;
      if (wr && bus.address == 2'd2)
        div_reg <= bus.writedata[DIV_W-1:0];
`ifdef TFT_SEQ_IRQ_EN
      if (wr && bus.address == 2'd3)
        ie <= bus.writedata[0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      hcnt     <= '0;
      div_lat  <= '0;
      tft_dc   <= 1'b0;
      tft_cs_n <= 1'b1;
      tft_sclk <= 1'b0;
    end else if (pop) begin
      // DIV is sampled only here, so mid-byte DIV writes wait for the next byte.
      shreg    <= head[7:0];
      tft_dc   <= head[8];
      div_lat  <= div_reg;
      bitcnt   <= 3'd7;
      hcnt     <= '0;
      tft_cs_n <= 1'b0;
      tft_sclk <= 1'b0;
      state    <= LOW;
    end else begin
      case (state)
        LOW: begin
          if (half_done) begin
            hcnt     <= '0;
            tft_sclk <= 1'b1;
            state    <= HIGH;
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
        HIGH: begin
          if (half_done) begin
            hcnt     <= '0;
            tft_sclk <= 1'b0;
            if (bitcnt != 3'd0) begin
              bitcnt <= bitcnt - 3'd1;
              shreg  <= {shreg[6:0], 1'b0};
              state  <= LOW;
            end else begin
              shreg    <= '0;
              tft_cs_n <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TFT_SEQ_IRQ_EN
  assign irq_pend = ie & ~busy;
`else
  assign irq_pend = 1'b0;
`endif
  assign irq = irq_pend;

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd1: bus.readdata = {16'd0, 8'(level), 3'd0, irq_pend, ovf, busy, full, empty};
      2'd2: bus.readdata = 32'(div_reg);
`ifdef TFT_SEQ_IRQ_EN
      2'd3: bus.readdata = {31'd0, ie};
`endif
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_tft_spi_seq.sv
// Scoreboard bench for tft_spi_seq: expected bytes queued at push, SPI monitor pops and compares.
module tb_tft_spi_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tft_dc, tft_cs_n, tft_sclk, tft_mosi, irq;

  always #5 clk = ~clk;

  tft_spi_seq_if bus();

  tft_spi_seq #(.FIFO_DEPTH(16), .DIV_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .tft_dc(tft_dc), .tft_cs_n(tft_cs_n), .tft_sclk(tft_sclk),
    .tft_mosi(tft_mosi), .irq(irq)
  );

  typedef struct {logic dc; logic [7:0] b; int half;} exp_t;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  int cur_div = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  // Push an entry; the model expects it on the wire with the DIV in force when it is loaded.
  task automatic push(input logic dc, input logic [7:0] b);
    exp_t e;
    e.dc = dc; e.b = b; e.half = cur_div + 1;
    sb.push_back(e);
    wr(2'd0, {23'd0, dc, b});
  endtask

  task automatic set_div(input int d);
    wr(2'd2, 32'(d));
    cur_div = d;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    int n = 0;
    rd(2'd1, st);
    while ((st[2] || sb.size() != 0) && n < 20000) begin
      rd(2'd1, st);
      n++;
    end
    check({tag, "_idle"}, {31'd0, st[2]}, 32'd0);
  endtask

  task automatic measure(input int exp_first, input int exp_low, input string tag);
    int n = 0, first = 0, low = 0;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (tft_sclk && first == 0) first = n;
      if (!tft_cs_n) low++;
      else if (low > 0) break;
    end
    check({tag, "_first_sclk"}, 32'(first), 32'(exp_first));
    check({tag, "_cs_low"}, 32'(low), 32'(exp_low));
  endtask

  // SPI monitor: rebuilds each byte from MOSI at SCLK rising edges.
  int m_bitn = 0, m_cyc = 0, m_last = 0;
  logic [7:0] m_sh;
  logic m_dc, m_prev = 1'b0;
  bit m_per_ok, m_dc_ok;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      m_cyc++;
      if (tft_cs_n) begin
        m_bitn = 0;
      end else if (!m_prev && tft_sclk) begin
        if (m_bitn == 0) begin
          m_dc = tft_dc; m_sh = '0; m_per_ok = 1'b1; m_dc_ok = 1'b1;
        end else begin
          if (sb.size() > 0 && (m_cyc - m_last) != 2 * sb[0].half) m_per_ok = 1'b0;
          if (tft_dc !== m_dc) m_dc_ok = 1'b0;
        end
        m_sh = {m_sh[6:0], tft_mosi};
        m_last = m_cyc;
        m_bitn++;
        if (m_bitn == 8) begin
          m_bitn = 0;
          if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", {m_dc, m_sh});
          end else begin
            e = sb.pop_front();
            check("spi_byte", {23'd0, m_dc, m_sh}, {23'd0, e.dc, e.b});
            check("sclk_period", {31'd0, m_per_ok}, 32'd1);
            check("dc_stable", {31'd0, m_dc_ok}, 32'd1);
          end
        end
      end
      m_prev = tft_sclk;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    check("rst_cs_n", {31'd0, tft_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, tft_sclk}, 32'd0);
    check("rst_mosi", {31'd0, tft_mosi}, 32'd0);
    check("rst_dc", {31'd0, tft_dc}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, d); check("rst_status", d, 32'h1);
    rd(2'd2, d); check("rst_div", d, 32'd4);
    rd(2'd0, d); check("txdata_read", d, 32'd0);

    // Single command byte at the fastest SCLK.
    set_div(0);
    push(1'b0, 8'h2A);
    measure(2, 16, "single");
    rd(2'd1, d); check("single_status", d, 32'h1);

    // Two queued bytes; measurement starts one cycle into the frame.
    set_div(1);
    push(1'b0, 8'h2A);
    push(1'b1, 8'h55);
    measure(2, 63, "pair");
    wait_idle("pair");

    // DIV change while the first byte is shifting.
    push(1'b0, 8'hC3);
    repeat (6) @(posedge clk);
    set_div(3);
    push(1'b1, 8'h5A);
    rd(2'd2, d); check("div_readback", d, 32'd3);
    wait_idle("divchg");

    // Randomized batches at random DIV.
    for (int r = 0; r < 6; r++) begin
      set_div($urandom_range(0, 3));
      for (int k = 0, n = $urandom_range(1, 6); k < n; k++) begin
        push(1'($urandom_range(0, 1)), 8'($urandom));
        repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      wait_idle("rand");
    end

    // Overflow: one byte in flight, then 16 fill the FIFO and the 17th is dropped.
    set_div(255);
    push(1'b0, 8'h11);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 16; k++) push(1'b1, 8'(k));
    wr(2'd0, 32'h1FF);
    rd(2'd1, d); check("ovf_status", d, 32'h100E);
    wr(2'd1, 32'h8);
    rd(2'd1, d); check("ovf_clear", d, 32'h1006);

    // Reset mid-transfer aborts everything.
    @(negedge clk) reset_n = 1'b0;
    sb.delete();
    #1;
    check("abort_cs_n", {31'd0, tft_cs_n}, 32'd1);
    check("abort_sclk", {31'd0, tft_sclk}, 32'd0);
    check("abort_mosi", {31'd0, tft_mosi}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    rd(2'd1, d); check("abort_status", d, 32'h1);
    rd(2'd2, d); check("abort_div", d, 32'd4);
    cur_div = 4;

`ifdef TFT_SEQ_IRQ_EN
    wr(2'd3, 32'h1);
    check("irq_idle", {31'd0, irq}, 32'd1);
    rd(2'd1, d); check("irq_status", d, 32'h11);
    push(1'b1, 8'h3C);
    check("irq_drop", {31'd0, irq}, 32'd0);
    begin
      int n = 0;
      bit seen_low = 1'b0;
      while (n < 2000 && !(seen_low && tft_cs_n)) begin
        @(posedge clk);
        #1;
        n++;
        if (!tft_cs_n) begin
          seen_low = 1'b1;
          if (irq) check("irq_busy", {31'd0, irq}, 32'd0);
        end
      end
      check("irq_rise", {31'd0, irq}, 32'd1);
    end
`else
    wr(2'd3, 32'h1);
    check("irq_off", {31'd0, irq}, 32'd0);
    rd(2'd3, d); check("irqen_absent", d, 32'd0);
    rd(2'd1, d); check("irq_status_off", d, 32'h1);
    push(1'b1, 8'h3C);
`endif
    wait_idle("final");
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
